door_code_tx: RTL and testbench

DOOR_CODE_TX -- requirements
Module: door_code_tx

---
 rtl/door_code_tx.sv | 174 +++++++++++++++++
 tb/tb_door_code_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/door_code_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | door_code_tx: sends a 3-digit code to a lock as strobed digits + confirm.  |
// | Option: DOOR_CODE_TX_DIGIT_CHECK_EN rejects non-BCD codes.  Rev 1.0       |
// +----------------------------------------------------------------------------+
module door_code_tx #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_hard_reset,
  input  logic [11:0] i_code,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [3:0]  o_digit,
  output logic        o_confirm_getter,
  output logic        o_confirm_FSM,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_digit_idx,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DIG_PULSE  = 3'd1,
    S_DIG_GAP    = 3'd2,
    S_CONF_PULSE = 3'd3,
    S_CONF_GAP   = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  // Counters hold "cycles remaining minus one" so a zero count means last cycle.
  localparam logic [7:0] c_pulse_load = 8'(PULSE_W - 1);
  localparam logic [7:0] c_gap_load   = 8'(GAP_W - 1);

  state_t      r_state;
  logic [11:0] r_code;
  logic [7:0]  r_cnt;
  logic [1:0]  r_idx;
  logic        w_go;

  function automatic logic [3:0] nibble_sel(input logic [11:0] code, input logic [1:0] idx);
    case (idx)
      2'd0:    nibble_sel = code[11:8];
      2'd1:    nibble_sel = code[7:4];
      default: nibble_sel = code[3:0];
    endcase
  endfunction

  assign w_go = i_start && !i_abort;

`ifdef DOOR_CODE_TX_DIGIT_CHECK_EN
  logic r_err;
  logic w_code_ok;
  assign w_code_ok = (i_code[11:8] <= 4'd9) && (i_code[7:4] <= 4'd9) && (i_code[3:0] <= 4'd9);
  assign o_err     = r_err;
`else
  logic w_code_ok;
  assign w_code_ok = 1'b1;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_hard_reset) begin
    if (i_hard_reset) begin
      r_state          <= S_IDLE;
      r_code           <= '0;
      r_cnt            <= '0;
      r_idx            <= '0;
      o_digit          <= '0;
      o_confirm_getter <= 1'b0;
      o_confirm_FSM    <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_digit_idx      <= '0;
`ifdef DOOR_CODE_TX_DIGIT_CHECK_EN
      r_err            <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef DOOR_CODE_TX_DIGIT_CHECK_EN
      r_err  <= 1'b0;
`endif
      if (r_state != S_IDLE && i_abort) begin
        r_state          <= S_IDLE;
        r_cnt            <= '0;
        r_idx            <= '0;
        o_digit          <= '0;
        o_confirm_getter <= 1'b0;
        o_confirm_FSM    <= 1'b0;
        o_busy           <= 1'b0;
        o_digit_idx      <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_go && w_code_ok) begin
              r_state          <= S_DIG_PULSE;
              r_code           <= i_code;
              r_idx            <= 2'd0;
              r_cnt            <= c_pulse_load;
              o_digit          <= i_code[11:8];
              o_digit_idx      <= 2'd0;
              o_confirm_getter <= 1'b1;
              o_busy           <= 1'b1;
            end
`ifdef DOOR_CODE_TX_DIGIT_CHECK_EN
            else if (w_go) begin
              r_err <= 1'b1;
            end
`endif
          end
          S_DIG_PULSE: begin
            if (r_cnt == 8'd0) begin
              r_state          <= S_DIG_GAP;
              r_cnt            <= c_gap_load;
              o_confirm_getter <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_DIG_GAP: begin
            if (r_cnt == 8'd0) begin
              r_cnt <= c_pulse_load;
              if (r_idx < 2'd2) begin
                r_state          <= S_DIG_PULSE;
                r_idx            <= r_idx + 2'd1;
                o_digit          <= nibble_sel(r_code, r_idx + 2'd1);
                o_digit_idx      <= r_idx + 2'd1;
                o_confirm_getter <= 1'b1;
              end else begin
                r_state       <= S_CONF_PULSE;
                o_digit       <= '0;
                o_digit_idx   <= 2'd3;
                o_confirm_FSM <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_CONF_PULSE: begin
            if (r_cnt == 8'd0) begin
              r_state       <= S_CONF_GAP;
              r_cnt         <= c_gap_load;
              o_confirm_FSM <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_CONF_GAP: begin
            if (r_cnt == 8'd0) begin
              // busy drops as done rises so the done cycle reads as "finished"
              r_state     <= S_DONE;
              r_cnt       <= '0;
              r_idx       <= '0;
              o_digit_idx <= '0;
              o_busy      <= 1'b0;
              o_done      <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_door_code_tx.sv
`default_nettype none
// Directed bench for door_code_tx at default timing (PULSE_W=2, GAP_W=4).
module tb_door_code_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] code = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  digit;
  logic        getter, confirm_fsm, busy, done, err;
  logic [1:0]  idx;

  int n_checks = 0;
  int n_errors = 0;

  door_code_tx #(.PULSE_W(2), .GAP_W(4)) dut (
    .i_clk            (clk),
    .i_hard_reset     (rst),
    .i_code           (code),
    .i_start          (start),
    .i_abort          (abort),
    .o_digit          (digit),
    .o_confirm_getter (getter),
    .o_confirm_FSM    (confirm_fsm),
    .o_busy           (busy),
    .o_done           (done),
    .o_digit_idx      (idx),
    .o_err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-written cycle table for the default timing.
  function automatic logic [3:0] exp_digit(input int c, input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
    if (c >= 1 && c <= 6)        return d0;
    else if (c >= 7 && c <= 12)  return d1;
    else if (c >= 13 && c <= 18) return d2;
    else                         return 4'd0;
  endfunction

  function automatic logic [1:0] exp_idx(input int c);
    if (c >= 1 && c <= 6)        return 2'd0;
    else if (c >= 7 && c <= 12)  return 2'd1;
    else if (c >= 13 && c <= 18) return 2'd2;
    else if (c >= 19 && c <= 24) return 2'd3;
    else                         return 2'd0;
  endfunction

  function automatic logic exp_getter(input int c);
    return (c == 1 || c == 2 || c == 7 || c == 8 || c == 13 || c == 14);
  endfunction

  function automatic logic exp_fsm(input int c);
    return (c == 19 || c == 20);
  endfunction

  function automatic logic exp_busy(input int c);
    return (c >= 1 && c <= 24);
  endfunction

  // Starts a transfer (edge 0 is the next posedge) and checks cycles 1..30.
  // restart_cyc/abort_cyc pulse i_start/i_abort during that cycle (0 = never).
  task automatic run_seq(input string name, input logic [11:0] c, input int restart_cyc,
                         input int abort_cyc, input logic release_rst);
    logic aborted;
    aborted = 1'b0;
    @(negedge clk);
    code  = c;
    start = 1'b1;
    if (release_rst) rst = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == restart_cyc);
      abort = (cyc == abort_cyc);
      if (abort_cyc != 0 && cyc > abort_cyc) aborted = 1'b1;
      check($sformatf("%s digit@c%0d", name, cyc), 32'(digit),
            aborted ? 32'd0 : 32'(exp_digit(cyc, c[11:8], c[7:4], c[3:0])));
      check($sformatf("%s idx@c%0d", name, cyc), 32'(idx), aborted ? 32'd0 : 32'(exp_idx(cyc)));
      check($sformatf("%s getter@c%0d", name, cyc), 32'(getter), aborted ? 32'd0 : 32'(exp_getter(cyc)));
      check($sformatf("%s conf@c%0d", name, cyc), 32'(confirm_fsm), aborted ? 32'd0 : 32'(exp_fsm(cyc)));
      check($sformatf("%s busy@c%0d", name, cyc), 32'(busy), aborted ? 32'd0 : 32'(exp_busy(cyc)));
      check($sformatf("%s done@c%0d", name, cyc), 32'(done), (!aborted && cyc == 25) ? 32'd1 : 32'd0);
      check($sformatf("%s err@c%0d", name, cyc), 32'(err), 32'd0);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #12;
    check("rst digit", 32'(digit), 32'd0);
    check("rst getter", 32'(getter), 32'd0);
    check("rst conf", 32'(confirm_fsm), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst idx", 32'(idx), 32'd0);
    check("rst err", 32'(err), 32'd0);

    // First start right at the first edge after reset release.
    run_seq("nominal", 12'h472, 0, 0, 1'b1);
    run_seq("restart", 12'h472, 5, 0, 1'b0);
    run_seq("abort", 12'h472, 0, 9, 1'b0);
    run_seq("code915", 12'h915, 0, 0, 1'b0);

    // Reset mid-strobe: outputs must clear without waiting for an edge.
    @(negedge clk);
    code = 12'h472; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("pre-rst getter", 32'(getter), 32'd1);
    rst = 1'b1;
    #1;
    check("async getter", 32'(getter), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async digit", 32'(digit), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("held done", 32'(done), 32'd0);
    check("held busy", 32'(busy), 32'd0);
    run_seq("post-rst", 12'h472, 0, 0, 1'b1);

    // Start and abort together in IDLE: nothing happens.
    @(negedge clk);
    code = 12'h472; start = 1'b1; abort = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin start = 1'b0; abort = 1'b0; end
      check($sformatf("sa busy@c%0d", cyc), 32'(busy), 32'd0);
      check($sformatf("sa getter@c%0d", cyc), 32'(getter), 32'd0);
      check($sformatf("sa conf@c%0d", cyc), 32'(confirm_fsm), 32'd0);
      check($sformatf("sa err@c%0d", cyc), 32'(err), 32'd0);
    end

`ifdef DOOR_CODE_TX_DIGIT_CHECK_EN
    @(negedge clk);
    code = 12'h4A2; start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start = 1'b0;
      check($sformatf("bad err@c%0d", cyc), 32'(err), (cyc == 1) ? 32'd1 : 32'd0);
      check($sformatf("bad busy@c%0d", cyc), 32'(busy), 32'd0);
      check($sformatf("bad getter@c%0d", cyc), 32'(getter), 32'd0);
      check($sformatf("bad conf@c%0d", cyc), 32'(confirm_fsm), 32'd0);
    end
`else
    run_seq("code4A2", 12'h4A2, 0, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
